crt_timing_controller: RTL and testbench

Sequences the CRT/VGA raster for the Pong display by consuming the pixel-rate signal from the CRT clock divider and stepping horizontal and vertical scan counters. From those counters it generates HSync, VSync, the VideoOn blanking flag, the current scan position, and a frame-start strobe for game-state update logic. The whole block runs on the single system `Clock`, and `PixelClock` is used only as a qualifier, never as a clock.

---
 rtl/crt_timing_controller.sv | 154 +++++++++++++++
 tb/tb_crt_timing_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/crt_timing_controller.sv
// ---------------------------------------------------------------------------
// crt_timing_controller
//
// Raster sequencer for the Pong CRT/VGA display. Horizontal and vertical scan
// counters advance on a pixel tick. Each counter drives a four-region FSM
// (active, front porch, sync, back porch). HSync, VSync, VideoOn and
// FrameStart are decoded from it. Everything runs on Clock. PixelClock only
// qualifies the advance and is never used as a clock.
//
// Optional feature (compile-time macro): CRT_PIXEL_EDGE_EN
//   defined   : PixelClock is a divided clock level. One tick is produced per
//               rising edge, detected against a registered copy.
//   undefined : PixelClock is a one-Clock-wide enable. tick = PixelClock.
//
// Ports
//   Clock      in   system clock
//   Reset      in   synchronous, active-high reset
//   PixelClock in   pixel-rate signal, synchronous to Clock
//   ScanX      out  [10:0] horizontal position, 0..H_TOTAL-1
//   ScanY      out  [10:0] vertical position, 0..V_TOTAL-1
//   HSync      out  horizontal sync, SYNC_POL while in the sync region
//   VSync      out  vertical sync, SYNC_POL while in the sync region
//   VideoOn    out  high inside the visible window
//   FrameStart out  one-cycle pulse after the counters wrap to (0,0)
// ---------------------------------------------------------------------------
module crt_timing_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PixelClock,
    output logic [10:0] ScanX,
    output logic [10:0] ScanY,
    output logic        HSync,
    output logic        VSync,
    output logic        VideoOn,
    output logic        FrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Region start positions and the last position before each wrap
    localparam logic [10:0] H_FP_START = 11'(H_ACTIVE);
    localparam logic [10:0] H_SY_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_BP_START = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_FP_START = 11'(V_ACTIVE);
    localparam logic [10:0] V_SY_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] V_BP_START = 11'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

    localparam logic [1:0] H_ACT = 2'd0;
    localparam logic [1:0] H_FP  = 2'd1;
    localparam logic [1:0] H_SY  = 2'd2;
    localparam logic [1:0] H_BP  = 2'd3;
    localparam logic [1:0] V_ACT = 2'd0;
    localparam logic [1:0] V_FP  = 2'd1;
    localparam logic [1:0] V_SY  = 2'd2;
    localparam logic [1:0] V_BP  = 2'd3;

    logic        tick;
    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] x_next;
    logic [10:0] y_next;
    logic [1:0]  h_state;
    logic [1:0]  h_state_next;
    logic [1:0]  v_state;
    logic [1:0]  v_state_next;

`ifdef CRT_PIXEL_EDGE_EN
    // pc_q also loads during Reset, so a PixelClock that is already high at
    // reset release is not seen as a rising edge.
    logic pc_q;

    always_ff @(posedge Clock) begin
        pc_q <= PixelClock;
    end

    assign tick = PixelClock & ~pc_q;
`else
    assign tick = PixelClock;
`endif

    assign h_wrap = tick && (ScanX == H_LAST);
    assign v_wrap = h_wrap && (ScanY == V_LAST);

    always_comb begin
        x_next = ScanX;
        y_next = ScanY;
        if (tick) begin
            x_next = h_wrap ? 11'd0 : ScanX + 11'd1;
        end
        if (h_wrap) begin
            y_next = v_wrap ? 11'd0 : ScanY + 11'd1;
        end
    end

    // A region changes on the step that moves the counter onto its start.
    // The FSMs step only when their counter steps, so they hold otherwise.
    always_comb begin
        h_state_next = h_state;
        if (tick) begin
            if (x_next == 11'd0)             h_state_next = H_ACT;
            else if (x_next == H_FP_START)   h_state_next = H_FP;
            else if (x_next == H_SY_START)   h_state_next = H_SY;
            else if (x_next == H_BP_START)   h_state_next = H_BP;
        end
    end

    always_comb begin
        v_state_next = v_state;
        if (h_wrap) begin
            if (y_next == 11'd0)             v_state_next = V_ACT;
            else if (y_next == V_FP_START)   v_state_next = V_FP;
            else if (y_next == V_SY_START)   v_state_next = V_SY;
            else if (y_next == V_BP_START)   v_state_next = V_BP;
        end
    end

    // The outputs are decoded from the next-state values. This keeps every
    // registered output aligned with the ScanX/ScanY it is registered with.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ScanX      <= 11'd0;
            ScanY      <= 11'd0;
            h_state    <= H_ACT;
            v_state    <= V_ACT;
            HSync      <= ~SYNC_POL;
            VSync      <= ~SYNC_POL;
            VideoOn    <= 1'b1;
            FrameStart <= 1'b0;
        end else begin
            ScanX      <= x_next;
            ScanY      <= y_next;
            h_state    <= h_state_next;
            v_state    <= v_state_next;
            HSync      <= (h_state_next == H_SY) ? SYNC_POL : ~SYNC_POL;
            VSync      <= (v_state_next == V_SY) ? SYNC_POL : ~SYNC_POL;
            VideoOn    <= (x_next < H_FP_START) && (y_next < V_FP_START);
            FrameStart <= v_wrap;
        end
    end

endmodule

// File: tb/tb_crt_timing_controller.sv
// ---------------------------------------------------------------------------
// tb_crt_timing_controller
//
// Directed bench on a small raster: H 8/2/2/2 (H_TOTAL 14) and V 4/1/1/1
// (V_TOTAL 7), with active-low syncs. Expected values come from hand
// constants and a simple position model: ex/ey plus fixed region bounds.
// Compile with or without CRT_PIXEL_EDGE_EN. The tick helper and the
// expectations that depend on the mode follow the macro.
// ---------------------------------------------------------------------------
module tb_crt_timing_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc;
    logic [10:0] sx;
    logic [10:0] sy;
    logic        hs;
    logic        vs;
    logic        von;
    logic        fs;

    int nvec = 0;
    int nerr = 0;
    int ex;
    int ey;

    always #5 clk = ~clk;

    crt_timing_controller #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .PixelClock(pc),
        .ScanX     (sx),
        .ScanY     (sy),
        .HSync     (hs),
        .VSync     (vs),
        .VideoOn   (von),
        .FrameStart(fs)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then sample away from it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        if (ex == 13) begin
            ex = 0;
            ey = (ey == 6) ? 0 : ey + 1;
        end else begin
            ex++;
        end
    endtask

    // Exactly one tick. It returns right after the tick edge, so FrameStart
    // is still visible to the caller.
    task automatic tick();
`ifdef CRT_PIXEL_EDGE_EN
        pc = 1'b0;
        cyc();
`endif
        pc = 1'b1;
        cyc();
        pc = 1'b0;
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc  = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        ex  = 0;
        ey  = 0;
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, "_x"}, sx, ex);
        chk({tag, "_y"}, sy, ey);
        chk({tag, "_von"}, von, (ex < 8 && ey < 4) ? 1 : 0);
        chk({tag, "_hs"}, hs, (ex == 10 || ex == 11) ? 0 : 1);
        chk({tag, "_vs"}, vs, (ey == 5) ? 0 : 1);
    endtask

    initial begin
        int vlow;
        int fcnt;
        rst = 1'b1;
        pc  = 1'b0;

        // Reset held while PixelClock toggles
        for (int i = 0; i < 2; i++) begin
            pc = (i == 0);
            cyc();
            chk("rst_x", sx, 0);
            chk("rst_y", sy, 0);
            chk("rst_von", von, 1);
            chk("rst_hs", hs, 1);
            chk("rst_vs", vs, 1);
            chk("rst_fs", fs, 0);
        end
        rst = 1'b0;
        pc  = 1'b0;
        ex  = 0;
        ey  = 0;
        cyc();
        chk_pos("idle0");

        // One full frame, with the line wrap and frame wrap checked
        vlow = 0;
        fcnt = 0;
        for (int t = 1; t <= 98; t++) begin
            tick();
            chk_pos("frm");
            chk("frm_fs", fs, (ex == 0 && ey == 0) ? 1 : 0);
            if (vs == 1'b0) vlow++;
            if (fs == 1'b1) fcnt++;
            if (t == 14) begin
                chk("line_wrap_x", sx, 0);
                chk("line_wrap_y", sy, 1);
            end
        end
        chk("vsync_ticks", vlow, 14);
        chk("fs_count", fcnt, 1);
        pc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fs_drop", fs, 0);
            chk_pos("hold");
        end

        // Reset in the middle of both sync pulses, together with a tick
        do_reset();
        for (int t = 0; t < 80; t++) tick();
        chk("mid_x", sx, 10);
        chk("mid_y", sy, 5);
        chk("mid_hs", hs, 0);
        chk("mid_vs", vs, 0);
        rst = 1'b1;
        pc  = 1'b1;
        cyc();
        chk("rtk_x", sx, 0);
        chk("rtk_y", sy, 0);
        chk("rtk_hs", hs, 1);
        chk("rtk_vs", vs, 1);
        chk("rtk_von", von, 1);
        chk("rtk_fs", fs, 0);
        rst = 1'b0;
        pc  = 1'b0;
        cyc();
        chk("rtk_after_x", sx, 0);

        // PixelClock high at reset release, then the divide-by-5 waveform
        rst = 1'b1;
        pc  = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
`ifdef CRT_PIXEL_EDGE_EN
        chk("pc_high_rel", sx, 0);
`else
        chk("pc_high_rel", sx, 2);
`endif
        pc = 1'b0;
        cyc();
        cyc();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 5; c++) begin
                pc = (c >= 2);
                cyc();
            end
        end
        pc = 1'b0;
`ifdef CRT_PIXEL_EDGE_EN
        chk("div5_x", sx, 2);
`else
        chk("div5_x", sx, 8);
`endif

`ifndef CRT_PIXEL_EDGE_EN
        // Full-rate ticks for 100 consecutive cycles
        do_reset();
        pc = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            adv();
            chk("fr_x", sx, ex);
            chk("fr_y", sy, ey);
            chk("fr_fs", fs, (i == 98) ? 1 : 0);
        end
        pc = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
